// File: rtl/mdu_pkg.sv
// mdu_pkg: shared encodings and sizes for the multiply/divide unit.
//   - mdu_op_e    : operation select driven by the EX stage
//   - mdu_state_e : top-level sequencing states
//   - mag()       : two's-complement magnitude helper used on divide operands
package mdu_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned DIV_ITER = 32;
  localparam int unsigned CNT_W    = $clog2(DIV_ITER);

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DIV  = 2'b10,
    FIX  = 2'b11
  } mdu_state_e;

  // Negate v when neg is set; 0x8000_0000 maps to itself, which is the
  // correct unsigned magnitude of the most negative value.
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + XLEN'(1)) : v;
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// mdu_div_core: iterative restoring radix-2 divider on unsigned magnitudes.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   load_i        : capture dividend_i/divisor_i and clear the iteration count
//   step_i        : perform one quotient-bit iteration this cycle
//   kill_i        : abandon the current division
//   dividend_i    : unsigned dividend magnitude
//   divisor_i     : unsigned divisor magnitude
//   quotient_o    : quotient shift register (final after the last step)
//   remainder_o   : partial remainder (final after the last step)
//   done_o        : high during the cycle whose step is the last iteration
module mdu_div_core
  import mdu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            step_i,
  input  logic            kill_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o,
  output logic            done_o
);

  logic [XLEN:0]    rem_q, rem_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  dvs_q;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q;

  logic [XLEN+1:0]  shifted;
  logic             take;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    take    = (shifted >= (XLEN+2)'(dvs_q));
    rem_d   = take ? (shifted[XLEN:0] - (XLEN+1)'(dvs_q)) : shifted[XLEN:0];
    quo_d   = {quo_q[XLEN-2:0], take};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else if (kill_i) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else if (load_i) begin
      rem_q  <= '0;
      quo_q  <= dividend_i;
      dvs_q  <= divisor_i;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else if (step_i) begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      cnt_q  <= cnt_q + CNT_W'(1);
      // Raised one step early so it is visible during the final step.
      done_q <= (cnt_q == CNT_W'(DIV_ITER - 2));
    end else begin
      done_q <= 1'b0;
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q[XLEN-1:0];
  assign done_o      = done_q;

endmodule

// File: rtl/mdu.sv
// mdu: iterative multiply/divide unit with architectural HI/LO registers.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start, op       : launch MULT/MULTU/DIV/DIVU (op 00/01/10/11) when idle
//   src_a, src_b    : rs / rt operands
//   flush           : cancel any in-flight operation, no HI/LO result write
//   hi_we, lo_we    : MTHI / MTLO commit of wdata
//   wdata           : MTHI / MTLO data
//   isbusy          : operation in flight (registered)
//   hi, lo          : HI / LO registers
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata,
  output logic            isbusy,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int unsigned MCNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  mdu_state_e        state_q;
  logic [MCNT_W-1:0] mcnt_q;
  logic [XLEN-1:0]   a_q, b_q;
  logic              sgn_q;
  logic              qneg_q, rneg_q, dbz_q;
  logic [XLEN-1:0]   hi_q, lo_q;
  logic              busy_q;

  mdu_op_e           op_e;
  logic              op_signed;
  logic              launch_div;
  logic [XLEN-1:0]   abs_a, abs_b;

  logic signed [XLEN:0]     mul_a, mul_b;
  logic signed [2*XLEN-1:0] prod;

  logic [XLEN-1:0]   div_quo, div_rem;
  logic              div_done;
  logic [XLEN-1:0]   q_fix, r_fix;

  // Operand decode for the launch cycle.
  always_comb begin
    op_e       = mdu_op_e'(op);
    op_signed  = (op_e == OP_MULT) || (op_e == OP_DIV);
    launch_div = start && !flush && (state_q == IDLE) && op[1];
    abs_a      = mag(src_a, op_signed && src_a[XLEN-1]);
    abs_b      = mag(src_b, op_signed && src_b[XLEN-1]);
  end

  // 33x33 signed product of sign/zero-extended operands; low 64 bits are exact.
  always_comb begin
    mul_a = $signed({sgn_q & a_q[XLEN-1], a_q});
    mul_b = $signed({sgn_q & b_q[XLEN-1], b_q});
    prod  = (2*XLEN)'(mul_a) * (2*XLEN)'(mul_b);
  end

  mdu_div_core u_div (
    .clk         (clk),
    .rst         (rst),
    .load_i      (launch_div),
    .step_i      (state_q == DIV),
    .kill_i      (flush),
    .dividend_i  (abs_a),
    .divisor_i   (abs_b),
    .quotient_o  (div_quo),
    .remainder_o (div_rem),
    .done_o      (div_done)
  );

  // Sign fixup applied in FIX.
  always_comb begin
    q_fix = mag(div_quo, qneg_q);
    r_fix = mag(div_rem, rneg_q);
  end

  // Sequencer and HI/LO. Result writes come after MTHI/MTLO so they win.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mcnt_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dbz_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      if (hi_we) hi_q <= wdata;
      if (lo_we) lo_q <= wdata;
      if (flush) begin
        state_q <= IDLE;
        mcnt_q  <= '0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              a_q    <= src_a;
              b_q    <= src_b;
              sgn_q  <= op_signed;
              mcnt_q <= '0;
              busy_q <= 1'b1;
              if (op[1]) begin
                qneg_q  <= op_signed && (src_a[XLEN-1] ^ src_b[XLEN-1]);
                rneg_q  <= op_signed && src_a[XLEN-1];
                dbz_q   <= (src_b == '0);
                state_q <= DIV;
              end else begin
                state_q <= MUL;
              end
            end
          end
          MUL: begin
            if (mcnt_q == MCNT_W'(MUL_LAT - 1)) begin
              hi_q    <= prod[2*XLEN-1:XLEN];
              lo_q    <= prod[XLEN-1:0];
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              mcnt_q <= mcnt_q + MCNT_W'(1);
            end
          end
          DIV: begin
            if (div_done) state_q <= FIX;
          end
          FIX: begin
            // Divide by zero returns the raw dividend with no sign fixup.
            if (dbz_q) begin
              hi_q <= a_q;
              lo_q <= '1;
            end else begin
              hi_q <= r_fix;
              lo_q <= q_fix;
            end
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign isbusy = busy_q;
  assign hi     = hi_q;
  assign lo     = lo_q;

endmodule

// File: doc/mdu.md
# mdu

Iterative multiply/divide unit with architectural HI/LO registers. Sits beside the EX stage: the EX stage issues MULT/MULTU/DIV/DIVU operands to it, and its `isbusy` output feeds the stall unit. The stall unit combines `isbusy` with the ID-stage HI/LO-access flag `RHL_visit` to hold MFHI/MFLO until the result is committed. MTHI/MTLO write HI/LO directly.

## Interface
Parameters:
- `MUL_LAT`, default 2: cycles from multiply start to HI/LO update (≥1).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  launch an operation. Asserted for one cycle when an EX-stage MULT/MULTU/DIV/DIVU advances.
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `src_a`  in  32  rs value (multiplicand or dividend).
- `src_b`  in  32  rt value (multiplier or divisor).
- `flush`  in  1  cancel the in-flight operation; driven by MEM1 exception or eret flush.
- `hi_we`  in  1  MTHI commit.
- `lo_we`  in  1  MTLO commit.
- `wdata`  in  32  data for MTHI/MTLO.
- `isbusy`  out  1  an operation is in flight.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- States: IDLE, MUL, DIV, FIX.
- `isbusy` is high whenever the state is not IDLE. It is decoded from registered state and has no combinational path from the inputs.
- **IDLE + start (no flush)**
  - op[1]=0: latch the operands and enter MUL with the counter at 0.
  - op[1]=1: latch |a|, |b| (signed ops only), the sign of the quotient (sa^sb) and the sign of the remainder (sa), then enter DIV with the counter at 0.
  - MULTU and DIVU treat operands as unsigned.
- **MUL**
  - Full 64-bit product: signed for MULT, unsigned for MULTU. A 33×33 signed product of the sign-/zero-extended operands is used.
  - The counter increments each cycle.
  - When the counter reaches MUL_LAT−1: {HI,LO} ← product, go to IDLE.
- **DIV**
  - Restoring radix-2 division, one quotient bit per cycle, 32 cycles.
  - Working registers: 33-bit partial remainder and 32-bit quotient/dividend shift register.
  - After the 32nd iteration, go to FIX.
- **FIX** (one cycle)
  - Negate the quotient if the quotient sign is set; negate the remainder if the remainder sign is set.
  - HI ← remainder, LO ← quotient, go to IDLE.
  - Signed 0x8000_0000 / −1 gives LO=0x8000_0000, HI=0.
- **Divide by zero** (`src_b`=0, signed or unsigned): HI ← `src_a`, LO ← 0xFFFF_FFFF. No sign fixup. Latency is unchanged (33 cycles).
- **`start` while busy**: ignored. The stall unit guarantees this case does not occur; the bench checks it.
- **`flush`**
  - Takes priority over everything except `rst`.
  - State → IDLE at the next edge and HI/LO are not updated.
  - When `flush` and `start` are asserted together, nothing is launched.
  - When `flush` coincides with the completion edge, no result is written.
- **`hi_we`/`lo_we`**
  - Write HI/LO at the next edge in any state.
  - When a write coincides with the completion edge, the operation result wins for both registers.

## Timing
- Reset: state IDLE, counter 0, `isbusy`=0, `hi`=0, `lo`=0. Reset mid-operation discards the operation.
- Multiply:
  - `start` sampled at edge t.
  - `isbusy`=1 during cycles t+1 … t+MUL_LAT.
  - HI/LO are valid after edge t+MUL_LAT, and `isbusy`=0 in the same cycle.
- Divide:
  - `start` sampled at edge t.
  - `isbusy`=1 for 33 cycles (32 DIV + 1 FIX).
  - HI/LO are updated at edge t+33.
- MTHI/MTLO: the written value is visible on `hi`/`lo` the cycle after the write-enable cycle.
- Outputs `hi`/`lo` are direct register outputs, so there is no same-cycle bypass of pending results.

## Structure
- Package `mdu_pkg`: op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), state enum (IDLE/MUL/DIV/FIX), DIV_ITER=32.
- Sub-module `mdu_div_core`:
  - Holds the iterative restoring divider: magnitude datapath, iteration counter and done pulse.
  - The top level keeps the FSM, the multiplier, sign fixup and the HI/LO registers.

## Test plan
- **MULT** −3 × 7, MUL_LAT=2:
  - `isbusy` high exactly 2 cycles.
  - HI=0xFFFF_FFFF, LO=0xFFFF_FFEB.
  - MULTU 0xFFFF_FFFF × 2 gives HI=1, LO=0xFFFF_FFFE.
- **DIV** −7 / 2:
  - `isbusy` high 33 cycles.
  - LO=0xFFFF_FFFD, HI=0xFFFF_FFFF.
  - DIVU 100 / 7 gives LO=14, HI=2.
- **Corner divides**:
  - DIV 0x8000_0000 / 0xFFFF_FFFF gives LO=0x8000_0000, HI=0.
  - DIVU 5 / 0 gives HI=5, LO=0xFFFF_FFFF.
- **Flush**:
  - Flush at cycle 10 of a DIV: `isbusy` falls the next cycle and HI/LO keep their prior values (0x1234, 0x5678).
  - Flush on the completion edge: no update.
- **MTHI/MTLO**:
  - `hi_we` with `wdata`=0xAAAA_0000 while idle: `hi`=0xAAAA_0000 the next cycle.
  - `lo_we` on a MULT completion edge: the product wins.
- **Reset and start-while-busy**:
  - `rst` during DIV cycle 5: `isbusy`=0 and `hi`=`lo`=0 next cycle.
  - A second `start` while busy has no effect on the result or the timing.
